axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL use fixed widths: 32-bit address, 32-bit data, 4-bit strobe.
REQ-002 The block SHALL expose exactly these ports (name  direction  width  meaning):
aclk  in  1  clock; all logic on rising edge
areset  in  1  reset, synchronous, active-high
req_valid  in  2  request pending, bit i = requester i
req_write  in  2  1 = write, 0 = read, per requester
req_addr  in  64  address; requester i on bits [32*i +: 32]
req_wdata  in  64  write data; requester i on bits [32*i +: 32]
req_wstrb  in  8  write strobes; requester i on bits [4*i +: 4]
req_ready  out  2  one-cycle one-hot accept pulse
resp_valid  out  2  one-cycle one-hot completion pulse
resp_rdata  out  32  read data of last completion
resp_err  out  1  last completion had resp[1]=1
m_awaddr  out  32  AXI-Lite write address
m_awvalid  out  1  write address valid
m_awready  in  1  write address ready
m_wdata  out  32  write data
m_wstrb  out  4  write strobes
m_wvalid  out  1  write data valid
m_wready  in  1  write data ready
m_bresp  in  2  write response
m_bvalid  in  1  write response valid
m_bready  out  1  write response ready
m_araddr  out  32  read address
m_arvalid  out  1  read address valid
m_arready  in  1  read address ready
m_rdata  in  32  read data
m_rresp  in  2  read response
m_rvalid  in  1  read valid
m_rready  out  1  read ready

Function
REQ-003 FSM states SHALL be IDLE, WRITE, WRITE_RESP, READ, READ_RESP; one transaction in flight.
REQ-004 IDLE with any req_valid: grant g = sole requester, or on tie g = !last_grant; req_ready[g]=1 combinationally that cycle only; at the edge latch addr/wdata/wstrb/write of g, set last_grant<=g, go to WRITE or READ.
REQ-005 WRITE: m_awvalid and m_wvalid SHALL both be high on entry; each drops the cycle after its own handshake; go to WRITE_RESP when both handshakes are done, including the same-cycle case.
REQ-006 WRITE_RESP: m_bready=1; on m_bvalid, latch m_bresp, set resp_rdata<=0, go to IDLE.
REQ-007 READ: m_arvalid=1 until m_arready, then go to READ_RESP; READ_RESP: m_rready=1; on m_rvalid, latch m_rdata and m_rresp, go to IDLE.
REQ-008 resp_valid[g] SHALL be a registered pulse in the cycle after the B/R handshake; resp_rdata and resp_err hold until the next completion.
REQ-009 Minimum latency with a zero-wait slave SHALL be: grant cycle 0, address/data handshake cycle 1, B/R handshake cycle 2, resp_valid cycle 3.
REQ-010 m_* address, data and strobe outputs SHALL come from latched registers and stay stable while the corresponding valid is high.
REQ-011 The IDLE cycle coinciding with resp_valid SHALL be able to grant a new request; req_valid held after req_ready counts as a new request.
REQ-012 m_bready and m_rready SHALL be low outside WRITE_RESP and READ_RESP; stray m_bvalid/m_rvalid SHALL be ignored.

Reset
REQ-013 With areset=1 at an edge: state=IDLE; all m_*valid, m_bready, m_rready, req_ready, resp_valid = 0; resp_rdata=0; resp_err=0; last_grant=1 so requester 0 wins the first tie; latched m_* address/data = 0.
REQ-014 Reset mid-transaction SHALL abandon the transaction with no resp_valid; the downstream slave is reset alongside.

Verification
REQ-015 Both requesters hold writes with req_valid=2'b11 -> req_ready sequence 01,10,01,10.
REQ-016 Req0 write addr 0x4, data 0xdeadbeef, strobe 0xF, zero-wait slave -> m_awaddr=0x4, m_wdata=0xdeadbeef, resp_valid=01 three cycles after grant, resp_err=0.
REQ-017 Req1 read addr 0x4, slave returns 0xdeadbeef with OKAY -> resp_valid=10, resp_rdata=0xdeadbeef.
REQ-018 m_wready immediate, m_awready delayed 3 cycles -> m_wvalid high 1 cycle, m_awvalid high 4 cycles, m_bready rises only after both handshakes.
REQ-019 Slave returns m_bresp=2'b10 -> resp_err=1 with resp_valid; the next OKAY completion clears it to 0.
REQ-020 areset pulsed in WRITE_RESP -> next cycle all outputs at reset values, no resp_valid; a subsequent tie grants requester 0.

Source files
------------

// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite master-side bus bundle used between the arbiter and its downstream slave.
interface axi_lite_arbiter_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-Lite master port.
//
// state      | meaning
// IDLE       | waiting for a request; grants combinationally
// WRITE      | AW and W channels active until each handshakes
// WRITE_RESP | waiting for B response
// READ       | AR channel active until handshake
// READ_RESP  | waiting for R response
module axi_lite_arbiter (
   input  logic                aclk,
   input  logic                areset,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_write,
   input  logic [63:0]         req_addr,
   input  logic [63:0]         req_wdata,
   input  logic [7:0]          req_wstrb,
   output logic [1:0]          req_ready,
   output logic [1:0]          resp_valid,
   output logic [31:0]         resp_rdata,
   output logic                resp_err,
   axi_lite_arbiter_if.master  m
);

   typedef enum logic [2:0] {
      IDLE, WRITE, WRITE_RESP, READ, READ_RESP
   } state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic        grant;
   logic        aw_done, w_done;
   logic        aw_hs, w_hs;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        unused_resp_lsb;

   assign unused_resp_lsb = ^{m.bresp[0], m.rresp[0]};

   assign m.awaddr = addr_q;
   assign m.araddr = addr_q;
   assign m.wdata  = wdata_q;
   assign m.wstrb  = wstrb_q;

   always_comb begin
      grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      state_nxt = state;
      req_ready = 2'b00;
      m.awvalid = 1'b0;
      m.wvalid  = 1'b0;
      m.bready  = 1'b0;
      m.arvalid = 1'b0;
      m.rready  = 1'b0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               req_ready = grant ? 2'b10 : 2'b01;
               state_nxt = req_write[grant] ? WRITE : READ;
            end
         end
         WRITE: begin
            m.awvalid = ~aw_done;
            m.wvalid  = ~w_done;
            aw_hs     = m.awvalid & m.awready;
            w_hs      = m.wvalid & m.wready;
            // Either channel may finish first, or both in the same cycle.
            if ((aw_done | aw_hs) && (w_done | w_hs))
               state_nxt = WRITE_RESP;
         end
         WRITE_RESP: begin
            m.bready = 1'b1;
            if (m.bvalid)
               state_nxt = IDLE;
         end
         READ: begin
            m.arvalid = 1'b1;
            if (m.arready)
               state_nxt = READ_RESP;
         end
         READ_RESP: begin
            m.rready = 1'b1;
            if (m.rvalid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         resp_valid <= 2'b00;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         resp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  addr_q     <= grant ? req_addr[63:32]  : req_addr[31:0];
                  wdata_q    <= grant ? req_wdata[63:32] : req_wdata[31:0];
                  wstrb_q    <= grant ? req_wstrb[7:4]   : req_wstrb[3:0];
                  last_grant <= grant;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
               end
            end
            WRITE: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            WRITE_RESP: begin
               if (m.bvalid) begin
                  resp_valid <= last_grant ? 2'b10 : 2'b01;
                  resp_rdata <= 32'h0;
                  resp_err   <= m.bresp[1];
               end
            end
            READ_RESP: begin
               if (m.rvalid) begin
                  resp_valid <= last_grant ? 2'b10 : 2'b01;
                  resp_rdata <= m.rdata;
                  resp_err   <= m.rresp[1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a behavioural AXI-Lite slave and a response scoreboard.
module tb_axi_lite_arbiter;

   logic        aclk = 1'b0;
   logic        areset;
   logic [1:0]  req_valid, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wstrb;
   logic [1:0]  req_ready, resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   axi_lite_arbiter_if bus ();

   axi_lite_arbiter dut (
      .aclk       (aclk),
      .areset     (areset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .m          (bus.master)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [1:0]  g;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          aw_c;
      int          w_c;
   } exp_t;

   exp_t        sb[$];
   logic [1:0]  gq[$];
   int          gcyc[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int grants_seen = 0;
   int resp_seen   = 0;
   int grant_cyc   = 0;
   int aw_hi = 0, w_hi = 0;
   bit bready_seen = 0;

   int          aw_delay = 0, w_delay = 0;
   logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
   logic [31:0] rdata_val = 32'h0;
   bit          b_hold = 0, stray_b = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave: reacts at the falling edge to what the DUT shows, so the DUT samples a settled value.
   initial begin
      int aw_n, w_n;
      aw_n = 0; w_n = 0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            bus.arready = 0; bus.rvalid = 0;
            aw_n = 0; w_n = 0;
         end else begin
            if (bus.awvalid) begin bus.awready = (aw_n >= aw_delay); aw_n++; end
            else begin bus.awready = 0; aw_n = 0; end
            if (bus.wvalid) begin bus.wready = (w_n >= w_delay); w_n++; end
            else begin bus.wready = 0; w_n = 0; end
            bus.arready = bus.arvalid;
            bus.bvalid  = (bus.bready & ~b_hold) | stray_b;
            bus.bresp   = bresp_val;
            bus.rvalid  = bus.rready | stray_b;
            bus.rdata   = rdata_val;
            bus.rresp   = rresp_val;
         end
      end
   end

   // Monitor: completions are handled before grants so latency uses the finishing transaction's grant.
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         #2;
         if (!areset) begin
            if (resp_valid != 2'b00) begin
               resp_seen++;
               if (sb.size() == 0) chk("resp_unexpected", resp_valid, 0);
               else begin
                  e = sb.pop_front();
                  chk("resp_valid", resp_valid, e.g);
                  chk("resp_rdata", resp_rdata, e.rdata);
                  chk("resp_err", resp_err, e.err);
                  if (e.lat > 0) chk("latency", cyc - grant_cyc, e.lat);
               end
            end
            if (req_ready != 2'b00) begin
               if (gq.size() == 0) chk("grant_unexpected", req_ready, 0);
               else chk("req_ready", req_ready, gq.pop_front());
               grant_cyc = cyc;
               gcyc.push_back(cyc);
               grants_seen++;
               aw_hi = 0; w_hi = 0; bready_seen = 0;
            end
            if (sb.size() > 0) begin
               if (bus.awvalid) begin aw_hi++; chk("m_awaddr", bus.awaddr, sb[0].addr); end
               if (bus.wvalid) begin
                  w_hi++;
                  chk("m_wdata", bus.wdata, sb[0].wdata);
                  chk("m_wstrb", bus.wstrb, sb[0].strb);
               end
               if (bus.arvalid) chk("m_araddr", bus.araddr, sb[0].addr);
               if (bus.bready && !bready_seen) begin
                  bready_seen = 1;
                  if (sb[0].aw_c > 0) begin
                     chk("awvalid_cycles", aw_hi, sb[0].aw_c);
                     chk("wvalid_cycles", w_hi, sb[0].w_c);
                  end
               end
            end
         end
      end
   end

   task automatic run_one(input int r, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] rdata, input logic err,
                          input int lat, input int aw_c, input int w_c);
      int g0, r0;
      exp_t e;
      @(negedge aclk);
      g0 = grants_seen; r0 = resp_seen;
      if (r == 0) begin
         req_addr[31:0] = addr; req_wdata[31:0] = data; req_wstrb[3:0] = strb; req_write[0] = wr;
         req_valid = 2'b01;
      end else begin
         req_addr[63:32] = addr; req_wdata[63:32] = data; req_wstrb[7:4] = strb; req_write[1] = wr;
         req_valid = 2'b10;
      end
      gq.push_back(req_valid);
      e.g = req_valid; e.addr = addr; e.wdata = data; e.strb = strb; e.rdata = rdata;
      e.err = err; e.lat = lat; e.aw_c = aw_c; e.w_c = w_c;
      sb.push_back(e);
      for (int i = 0; i < 20 && grants_seen == g0; i++) @(negedge aclk);
      req_valid = 2'b00;
      chk("grant_done", grants_seen, g0 + 1);
      for (int i = 0; i < 100 && resp_seen == r0; i++) @(negedge aclk);
      chk("resp_done", resp_seen, r0 + 1);
   endtask

   initial begin
      int g0, r0;
      exp_t e;
      areset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      repeat (3) @(negedge aclk);
      #2;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
      chk("rst_rdata_err", {resp_rdata, resp_err}, 0);
      chk("rst_addr_data", {bus.awaddr, bus.wdata}, 0);
      @(negedge aclk);
      areset = 0;

      // Both requesters hold writes: alternate starting from requester 0, back-to-back grants.
      @(negedge aclk);
      g0 = grants_seen; r0 = resp_seen;
      req_addr = {32'h200, 32'h100}; req_wdata = {32'hbbbb0001, 32'haaaa0000};
      req_wstrb = 8'hff; req_write = 2'b11; req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         gq.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
         e.g = (k % 2 == 0) ? 2'b01 : 2'b10;
         e.addr = (k % 2 == 0) ? 32'h100 : 32'h200;
         e.wdata = (k % 2 == 0) ? 32'haaaa0000 : 32'hbbbb0001;
         e.strb = 4'hf; e.rdata = 0; e.err = 0; e.lat = 3; e.aw_c = 1; e.w_c = 1;
         sb.push_back(e);
      end
      for (int i = 0; i < 100 && grants_seen < g0 + 4; i++) @(negedge aclk);
      req_valid = 2'b00;
      chk("tie_grants", grants_seen, g0 + 4);
      for (int i = 0; i < 100 && resp_seen < r0 + 4; i++) @(negedge aclk);
      chk("tie_resps", resp_seen, r0 + 4);
      if (gcyc.size() >= g0 + 4) chk("tie_spacing", gcyc[g0 + 3] - gcyc[g0], 9);

      run_one(0, 1, 32'h4, 32'hdeadbeef, 4'hf, 32'h0, 1'b0, 3, 1, 1);

      rdata_val = 32'hdeadbeef; rresp_val = 2'b00;
      run_one(1, 0, 32'h4, 32'h0, 4'h0, 32'hdeadbeef, 1'b0, 3, 0, 0);

      aw_delay = 3;
      run_one(0, 1, 32'h8, 32'h12345678, 4'h3, 32'h0, 1'b0, 6, 4, 1);
      aw_delay = 0;

      bresp_val = 2'b10;
      run_one(1, 1, 32'hc, 32'h0badf00d, 4'hc, 32'h0, 1'b1, 3, 1, 1);
      bresp_val = 2'b00;
      repeat (2) @(negedge aclk);
      #2 chk("err_hold", resp_err, 1);
      rdata_val = 32'hcafef00d;
      run_one(0, 0, 32'h10, 32'h0, 4'h0, 32'hcafef00d, 1'b0, 3, 0, 0);

      // Stray B/R valids while idle must not complete anything.
      r0 = resp_seen;
      @(negedge aclk);
      stray_b = 1;
      repeat (3) @(negedge aclk);
      stray_b = 0;
      repeat (2) @(negedge aclk);
      chk("stray_no_resp", resp_seen, r0);

      // Reset while waiting for B: no completion, outputs cleared, next tie goes to requester 0.
      b_hold = 1;
      @(negedge aclk);
      g0 = grants_seen; r0 = resp_seen;
      req_addr[31:0] = 32'h30; req_wdata[31:0] = 32'h77; req_wstrb[3:0] = 4'hf; req_write[0] = 1;
      req_valid = 2'b01;
      gq.push_back(2'b01);
      e.g = 2'b01; e.addr = 32'h30; e.wdata = 32'h77; e.strb = 4'hf; e.rdata = 0; e.err = 0;
      e.lat = 0; e.aw_c = 0; e.w_c = 0;
      sb.push_back(e);
      for (int i = 0; i < 20 && grants_seen == g0; i++) @(negedge aclk);
      req_valid = 2'b00;
      for (int i = 0; i < 20 && !bus.bready; i++) @(negedge aclk);
      chk("reached_write_resp", bus.bready, 1);
      areset = 1;
      @(negedge aclk);
      #2;
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
      chk("mid_rst_rdata_err", {resp_rdata, resp_err}, 0);
      chk("mid_rst_addr_data", {bus.awaddr, bus.wdata, 4'h0, bus.wstrb}, 0);
      @(negedge aclk);
      areset = 0;
      sb.delete();
      b_hold = 0;
      repeat (3) @(negedge aclk);
      chk("mid_rst_no_resp", resp_seen, r0);

      @(negedge aclk);
      g0 = grants_seen; r0 = resp_seen;
      rdata_val = 32'h5a5a5a5a;
      req_addr = {32'h20, 32'h18}; req_write = 2'b00; req_valid = 2'b11;
      gq.push_back(2'b01);
      e.g = 2'b01; e.addr = 32'h18; e.wdata = 0; e.strb = 0; e.rdata = 32'h5a5a5a5a; e.err = 0;
      e.lat = 3; e.aw_c = 0; e.w_c = 0;
      sb.push_back(e);
      for (int i = 0; i < 20 && grants_seen == g0; i++) @(negedge aclk);
      req_valid = 2'b00;
      chk("post_rst_grant", grants_seen, g0 + 1);
      for (int i = 0; i < 100 && resp_seen == r0; i++) @(negedge aclk);
      chk("post_rst_resp", resp_seen, r0 + 1);

      repeat (3) @(negedge aclk);
      chk("sb_empty", sb.size(), 0);
      chk("gq_empty", gq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
